// File: rtl/matmul_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : matmul_seq_if
// Description : Job handshake and DRAM port bundle for the matrix-multiply
//               sequencer. The slave side is the sequencer; the master side
//               is the control unit / memory environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface matmul_seq_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] dim_m;
  logic [ADDR_W-1:0] dim_k;
  logic [ADDR_W-1:0] dim_n;
  logic [ADDR_W-1:0] base_a;
  logic [ADDR_W-1:0] base_b;
  logic [ADDR_W-1:0] base_c;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [WIDTH-1:0]  mem_rdata;
  logic              mem_wr;
  logic [WIDTH-1:0]  mem_wdata;

  modport master (
    output start, dim_m, dim_k, dim_n, base_a, base_b, base_c, mem_rdata,
    input  busy, done, mem_addr, mem_rd, mem_wr, mem_wdata
  );

  modport slave (
    input  start, dim_m, dim_k, dim_n, base_a, base_b, base_c, mem_rdata,
    output busy, done, mem_addr, mem_rd, mem_wr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/matmul_seq.sv
`default_nettype none
// ============================================================================
// Module      : matmul_seq
// Description : Sequencer computing C = A x B over a single-port DRAM.
//               A is MxK, B is KxN, C is MxN, all row-major. Each output
//               element takes 3K+1 cycles (K x {RD_A, RD_B, MAC} + WR_C).
//               Optional feature macro MATMUL_SAT_EN: unsigned saturating
//               accumulation; otherwise the accumulator wraps mod 2^WIDTH.
// Revision    : 1.0 - initial release
// ============================================================================
module matmul_seq #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  matmul_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_A = 3'd1,
    S_RD_B = 3'd2,
    S_MAC  = 3'd3,
    S_WR_C = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] c_one = ADDR_W'(1);

  state_t            r_state;
  state_t            w_next_state;

  // Latched job descriptor
  logic [ADDR_W-1:0] r_dim_m;
  logic [ADDR_W-1:0] r_dim_k;
  logic [ADDR_W-1:0] r_dim_n;
  logic [ADDR_W-1:0] r_base_b;

  // Loop counters and running address pointers. Row pointers advance by
  // K (for A) and N (for C) when i increments, and the B pointer walks down
  // a column by N per k step, so no multiplier is needed for addressing.
  logic [ADDR_W-1:0] r_i;
  logic [ADDR_W-1:0] r_j;
  logic [ADDR_W-1:0] r_k;
  logic [ADDR_W-1:0] r_a_row;
  logic [ADDR_W-1:0] r_c_row;
  logic [ADDR_W-1:0] r_b_ptr;

  logic [WIDTH-1:0]  r_a_reg;
  logic [WIDTH-1:0]  r_acc;
  logic [WIDTH-1:0]  w_acc_next;

  logic              w_last_k;
  logic              w_last_j;
  logic              w_last_i;
  logic              w_zero_dim;

  assign w_last_k   = (r_k == r_dim_k - c_one);
  assign w_last_j   = (r_j == r_dim_n - c_one);
  assign w_last_i   = (r_i == r_dim_m - c_one);
  assign w_zero_dim = (bus.dim_m == '0) || (bus.dim_k == '0) || (bus.dim_n == '0);

`ifdef MATMUL_SAT_EN
  localparam logic [WIDTH-1:0] c_acc_max = '1;

  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH:0]   w_sum;

  // Full-width product and sum; any bit above WIDTH means overflow, and a
  // saturated accumulator stays saturated because products are unsigned.
  always_comb begin
    w_prod     = {{WIDTH{1'b0}}, r_a_reg} * {{WIDTH{1'b0}}, bus.mem_rdata};
    w_sum      = {1'b0, w_prod} + {{(WIDTH+1){1'b0}}, r_acc};
    w_acc_next = (|w_sum[2*WIDTH:WIDTH]) ? c_acc_max : w_sum[WIDTH-1:0];
  end
`else
  logic [WIDTH-1:0] w_prod_lo;

  // Wrapping accumulation only needs the low WIDTH bits of the product.
  always_comb begin
    w_prod_lo  = r_a_reg * bus.mem_rdata;
    w_acc_next = r_acc + w_prod_lo;
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic and registered-state output decode
  always_comb begin
    w_next_state  = r_state;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    bus.mem_rd    = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_next_state = w_zero_dim ? S_DONE : S_RD_A;
        end
      end
      S_RD_A: begin
        bus.busy     = 1'b1;
        bus.mem_rd   = 1'b1;
        bus.mem_addr = r_a_row + r_k;
        w_next_state = S_RD_B;
      end
      S_RD_B: begin
        bus.busy     = 1'b1;
        bus.mem_rd   = 1'b1;
        bus.mem_addr = r_b_ptr;
        w_next_state = S_MAC;
      end
      S_MAC: begin
        bus.busy     = 1'b1;
        w_next_state = w_last_k ? S_WR_C : S_RD_A;
      end
      S_WR_C: begin
        bus.busy      = 1'b1;
        bus.mem_wr    = 1'b1;
        bus.mem_addr  = r_c_row + r_j;
        bus.mem_wdata = r_acc;
        w_next_state  = (w_last_i && w_last_j) ? S_DONE : S_RD_A;
      end
      S_DONE: begin
        bus.done     = 1'b1;
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Datapath: job latch, loop counters, address pointers and accumulator
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dim_m  <= '0;
      r_dim_k  <= '0;
      r_dim_n  <= '0;
      r_base_b <= '0;
      r_i      <= '0;
      r_j      <= '0;
      r_k      <= '0;
      r_a_row  <= '0;
      r_c_row  <= '0;
      r_b_ptr  <= '0;
      r_a_reg  <= '0;
      r_acc    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_dim_m  <= bus.dim_m;
            r_dim_k  <= bus.dim_k;
            r_dim_n  <= bus.dim_n;
            r_base_b <= bus.base_b;
            r_a_row  <= bus.base_a;
            r_c_row  <= bus.base_c;
            r_b_ptr  <= bus.base_b;
            r_i      <= '0;
            r_j      <= '0;
            r_k      <= '0;
            r_acc    <= '0;
          end
        end
        S_RD_B: begin
          r_a_reg <= bus.mem_rdata;
        end
        S_MAC: begin
          r_acc <= w_acc_next;
          if (w_last_k) begin
            r_k <= '0;
          end else begin
            r_k     <= r_k + c_one;
            r_b_ptr <= r_b_ptr + r_dim_n;
          end
        end
        S_WR_C: begin
          r_acc <= '0;
          if (w_last_j) begin
            // Next row of C: restart B at column 0, move A and C rows down.
            r_j     <= '0;
            r_i     <= r_i + c_one;
            r_a_row <= r_a_row + r_dim_k;
            r_c_row <= r_c_row + r_dim_n;
            r_b_ptr <= r_base_b;
          end else begin
            r_j     <= r_j + c_one;
            r_b_ptr <= r_base_b + r_j + c_one;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire
